alu_seq_ctrl: RTL and testbench

- Initiator-side sequencer for the 8-bit carry-lookahead add/sub unit.
- Accepts operation requests over a valid/ready handshake and drives the adder's operand/select/start inputs.
- Captures sum, carry and flags, and returns a registered response.
- Builds multi-cycle unsigned MUL (shift-add) and DIV (restoring) on the same adder; sits between the instruction decoder and the adder.

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_seq_ctrl_if.sv | 19 +
 rtl/alu_seq_step.sv | 38 +++
 rtl/alu_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants, encodings and flag helpers for the alu_seq_ctrl sequencer.
package alu_seq_pkg;
  localparam int WIDTH = 8;
  localparam int ITER  = 8;
  localparam int CW    = $clog2(ITER);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDSUB = 3'd1,
    ST_MUL    = 3'd2,
    ST_DIV    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int FLG_ERR = 4;
  localparam int FLG_C   = 3;
  localparam int FLG_V   = 2;
  localparam int FLG_N   = 1;
  localparam int FLG_Z   = 0;

  function automatic logic [4:0] mk_flags(input logic err, c, v, n, z);
    logic [4:0] f;
    f          = '0;
    f[FLG_ERR] = err;
    f[FLG_C]   = c;
    f[FLG_V]   = v;
    f[FLG_N]   = n;
    f[FLG_Z]   = z;
    return f;
  endfunction
endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response bus between the instruction decoder (master) and the sequencer (slave).
interface alu_seq_ctrl_if;
  import alu_seq_pkg::*;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_lo;
  logic [WIDTH-1:0] rsp_hi;
  logic [4:0]       rsp_flags;

  modport master (output req_valid, req_op, req_a, req_b, rsp_ready,
                  input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_flags);
  modport slave  (input  req_valid, req_op, req_a, req_b, rsp_ready,
                  output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_flags);
endinterface

// File: rtl/alu_seq_step.sv
// One MUL (shift-add) or DIV (restoring) iteration; hi/lo hold acc_hi/acc_lo or R/Q.
// DIV path only present with ALU_SEQ_DIV_EN defined.
module alu_seq_step
  import alu_seq_pkg::*;
(
`ifdef ALU_SEQ_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] add_z,
  input  logic             add_c8,
  output logic [WIDTH-1:0] trial_x,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);
  logic [WIDTH:0] sum_hi;

  always_comb begin
    trial_x = hi;
    sum_hi  = lo[0] ? {add_c8, add_z} : {1'b0, hi};
    nxt_hi  = sum_hi[WIDTH:1];
    nxt_lo  = {sum_hi[0], lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    if (is_div) begin
      // Shifted-out MSB means R already exceeds any 8-bit divisor.
      trial_x = {hi[WIDTH-2:0], lo[WIDTH-1]};
      if (hi[WIDTH-1] | add_c8) begin
        nxt_hi = add_z;
        nxt_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = trial_x;
        nxt_lo = {lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end
endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer driving the external 8-bit add/sub unit for ADD/SUB/MUL/DIV requests.
// Build option: ALU_SEQ_DIV_EN enables the restoring divider; otherwise DIV returns err.
module alu_seq_ctrl
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  alu_seq_ctrl_if.slave    bus,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_select,
  output logic             add_start,
  input  logic [WIDTH-1:0] add_z,
  input  logic             add_c8,
  input  logic             add_overflow,
  input  logic             add_negative,
  input  logic             add_zero
);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_lo_q, rsp_lo_d, rsp_hi_q, rsp_hi_d;
  logic [4:0]       rsp_flags_q, rsp_flags_d;
  logic [WIDTH-1:0] step_x, step_hi, step_lo;

  alu_seq_step u_step (
`ifdef ALU_SEQ_DIV_EN
    .is_div  (state_q == ST_DIV),
`endif
    .hi      (hi_q),
    .lo      (lo_q),
    .add_z   (add_z),
    .add_c8  (add_c8),
    .trial_x (step_x),
    .nxt_hi  (step_hi),
    .nxt_lo  (step_lo)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_lo_d    = rsp_lo_q;
    rsp_hi_d    = rsp_hi_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid) begin
        op_d  = op_e'(bus.req_op);
        a_d   = bus.req_a;
        b_d   = bus.req_b;
        cnt_d = '0;
        hi_d  = '0;
        case (op_e'(bus.req_op))
          OP_MUL: begin state_d = ST_MUL; lo_d = bus.req_b; end
`ifdef ALU_SEQ_DIV_EN
          OP_DIV: begin state_d = ST_DIV; lo_d = bus.req_a; end
`endif
          default: state_d = ST_ADDSUB;
        endcase
      end
      ST_ADDSUB: begin
        // Without the divider, op 11 also passes through here as an error response.
        state_d     = ST_DONE;
        rsp_valid_d = 1'b1;
        rsp_hi_d    = '0;
        if (op_q[1]) begin
          rsp_lo_d    = '0;
          rsp_flags_d = mk_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
          rsp_lo_d    = add_z;
          rsp_flags_d = mk_flags(1'b0, add_c8, add_overflow, add_negative, add_zero);
        end
      end
      ST_MUL: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_lo_d    = step_lo;
          rsp_hi_d    = step_hi;
          rsp_flags_d = mk_flags(1'b0, step_hi != '0, 1'b0, 1'b0,
                                 {step_hi, step_lo} == '0);
        end
      end
`ifdef ALU_SEQ_DIV_EN
      ST_DIV: begin
        if (b_q == '0) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_lo_d    = '1;
          rsp_hi_d    = a_q;
          rsp_flags_d = mk_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            rsp_lo_d    = step_lo;
            rsp_hi_d    = step_hi;
            rsp_flags_d = mk_flags(1'b0, 1'b0, 1'b0, 1'b0, step_lo == '0);
          end
        end
      end
`endif
      ST_DONE: if (bus.rsp_ready) begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    add_x      = '0;
    add_y      = '0;
    add_select = 1'b0;
    add_start  = 1'b0;
    case (state_q)
      ST_ADDSUB: if (!op_q[1]) begin
        add_x      = a_q;
        add_y      = b_q;
        add_select = op_q[0];
        add_start  = 1'b1;
      end
      ST_MUL: begin
        add_x = step_x;
        add_y = a_q;
      end
`ifdef ALU_SEQ_DIV_EN
      ST_DIV: begin
        add_x      = step_x;
        add_y      = b_q;
        add_select = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_lo_q    <= '0;
      rsp_hi_q    <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_lo_q    <= rsp_lo_d;
      rsp_hi_q    <= rsp_hi_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_lo    = rsp_lo_q;
  assign bus.rsp_hi    = rsp_hi_q;
  assign bus.rsp_flags = rsp_flags_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural model of the 8-bit add/sub unit.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [4:0] flags;
    logic [7:0] lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] add_x, add_y, add_z, yy;
  logic       add_select, add_start, add_c8, add_overflow, add_negative, add_zero;
  logic [8:0] sum;
  int         errors = 0;
  int         checks = 0;
  exp_t       sb[$];

  alu_seq_ctrl_if bus();

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .add_x(add_x), .add_y(add_y), .add_select(add_select), .add_start(add_start),
    .add_z(add_z), .add_c8(add_c8), .add_overflow(add_overflow),
    .add_negative(add_negative), .add_zero(add_zero)
  );

  always #5 clk = ~clk;

  always_comb begin
    yy  = add_select ? ~add_y : add_y;
    sum = {1'b0, add_x} + {1'b0, yy} + {8'd0, add_select};
  end
  assign add_z        = sum[7:0];
  assign add_c8       = sum[8];
  assign add_overflow = add_start & (add_x[7] == yy[7]) & (sum[7] != add_x[7]);
  assign add_negative = add_start & sum[7];
  assign add_zero     = add_start & (sum[7:0] == 8'd0);

  function automatic exp_t ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [8:0] s;
    logic [15:0] p;
    e = '0;
    e.lat = 8'd1;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        e.lo = s[7:0];
        e.flags = {1'b0, s[8], (a[7] == b[7]) && (s[7] != a[7]), s[7], s[7:0] == 8'd0};
      end
      2'b01: begin
        e.lo = a - b;
        e.flags = {1'b0, a >= b, (a[7] != b[7]) && (e.lo[7] != a[7]), e.lo[7], e.lo == 8'd0};
      end
      2'b10: begin
        p = {8'd0, a} * {8'd0, b};
        e.lo = p[7:0];
        e.hi = p[15:8];
        e.flags = {1'b0, p[15:8] != 8'd0, 1'b0, 1'b0, p == 16'd0};
        e.lat = 8'd8;
      end
      default: begin
`ifdef ALU_SEQ_DIV_EN
        if (b == 8'd0) begin
          e.lo = 8'hFF;
          e.hi = a;
          e.flags = 5'b10000;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
          e.flags = {4'b0000, e.lo == 8'd0};
          e.lat = 8'd8;
        end
`else
        e.flags = 5'b10000;
`endif
      end
    endcase
    return e;
  endfunction

  // Pushes the expectation, waits for req_ready, and performs the accept edge.
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    sb.push_back(ref_op(op, a, b));
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL send_ready: req_ready=%b, wanted 1 within 50 cycles", bus.req_ready);
    end
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic ack();
    @(negedge clk) bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs: ready=%b valid=%b, want 1 0", bus.req_ready, bus.rsp_valid);
    end
    checks++;
    if ({bus.rsp_lo, bus.rsp_hi, bus.rsp_flags} !== 21'd0) begin
      errors++; $display("FAIL reset_rsp: lo=%h hi=%h flg=%b, want zeros", bus.rsp_lo, bus.rsp_hi, bus.rsp_flags);
    end
    checks++;
    if ({add_x, add_y, add_select, add_start} !== 18'd0) begin
      errors++; $display("FAIL reset_add: x=%h y=%h sel=%b st=%b, want zeros", add_x, add_y, add_select, add_start);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_addsub();
    logic [1:0] ops [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic [7:0] as  [4] = '{8'd50, 8'd127, 8'd100, 8'd30};
    logic [7:0] bs  [4] = '{8'd30, 8'd1, 8'd100, 8'd50};
    exp_t e;
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], as[i], bs[i]);
      checks++;
      if (add_start !== 1'b1 || add_x !== as[i] || add_y !== bs[i] || add_select !== ops[i][0]) begin
        errors++;
        $display("FAIL addsub_drive%0d: x=%h y=%h sel=%b st=%b, want %h %h %b 1",
                 i, add_x, add_y, add_select, add_start, as[i], bs[i], ops[i][0]);
      end
      wait_rsp(lat);
      e = sb.pop_front();
      checks++;
      if ({bus.rsp_lo, bus.rsp_hi, bus.rsp_flags} !== {e.lo, e.hi, e.flags} || lat != int'(e.lat)) begin
        errors++;
        $display("FAIL addsub%0d: got lo=%h hi=%h flg=%b lat=%0d, want lo=%h hi=%h flg=%b lat=%0d",
                 i, bus.rsp_lo, bus.rsp_hi, bus.rsp_flags, lat, e.lo, e.hi, e.flags, e.lat);
      end
      ack();
    end
  endtask

  task automatic test_muldiv();
    logic [1:0] ops [5] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
    logic [7:0] as  [5] = '{8'd200, 8'd0, 8'd200, 8'd5, 8'd3};
    logic [7:0] bs  [5] = '{8'd200, 8'd255, 8'd7, 8'd0, 8'd9};
    exp_t e;
    int lat;
    for (int i = 0; i < 5; i++) begin
      send(ops[i], as[i], bs[i]);
      checks++;
      if (add_start !== 1'b0) begin
        errors++; $display("FAIL muldiv_start%0d: add_start=%b, want 0", i, add_start);
      end
      wait_rsp(lat);
      e = sb.pop_front();
      checks++;
      if ({bus.rsp_lo, bus.rsp_hi, bus.rsp_flags} !== {e.lo, e.hi, e.flags} || lat != int'(e.lat)) begin
        errors++;
        $display("FAIL muldiv%0d: got lo=%h hi=%h flg=%b lat=%0d, want lo=%h hi=%h flg=%b lat=%0d",
                 i, bus.rsp_lo, bus.rsp_hi, bus.rsp_flags, lat, e.lo, e.hi, e.flags, e.lat);
      end
      ack();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int lat;
    send(2'b10, 8'd200, 8'd200);
    wait_rsp(lat);
    e = sb.pop_front();
    checks++;
    if ({bus.rsp_lo, bus.rsp_hi, bus.rsp_flags} !== {e.lo, e.hi, e.flags} || lat != int'(e.lat)) begin
      errors++;
      $display("FAIL bp_rsp: got lo=%h hi=%h flg=%b lat=%0d, want lo=%h hi=%h flg=%b lat=%0d",
               bus.rsp_lo, bus.rsp_hi, bus.rsp_flags, lat, e.lo, e.hi, e.flags, e.lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
          {bus.rsp_lo, bus.rsp_hi, bus.rsp_flags} !== {e.lo, e.hi, e.flags}) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b ready=%b lo=%h hi=%h flg=%b, want 1 0 %h %h %b",
                 i, bus.rsp_valid, bus.req_ready, bus.rsp_lo, bus.rsp_hi, bus.rsp_flags, e.lo, e.hi, e.flags);
      end
    end
    // Request presented together with the response handshake must wait one cycle.
    sb.push_back(ref_op(2'b00, 8'd3, 8'd4));
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_op = 2'b00; bus.req_a = 8'd3; bus.req_b = 8'd4; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: valid=%b ready=%b, want 0 1", bus.rsp_valid, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL bp_accept: req_ready=%b, want 0", bus.req_ready);
    end
    wait_rsp(lat);
    e = sb.pop_front();
    checks++;
    if ({bus.rsp_lo, bus.rsp_hi, bus.rsp_flags} !== {e.lo, e.hi, e.flags} || lat != int'(e.lat)) begin
      errors++;
      $display("FAIL bp_next: got lo=%h hi=%h flg=%b lat=%0d, want lo=%h hi=%h flg=%b lat=%0d",
               bus.rsp_lo, bus.rsp_hi, bus.rsp_flags, lat, e.lo, e.hi, e.flags, e.lat);
    end
    ack();
  endtask

  task automatic test_reset_mid_mul();
    exp_t e;
    int lat;
    send(2'b10, 8'd13, 8'd11);
    void'(sb.pop_back());
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || add_start !== 1'b0 || bus.req_ready !== 1'b1 || add_x !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid: valid=%b start=%b ready=%b x=%h, want 0 0 1 00",
               bus.rsp_valid, add_start, bus.req_ready, add_x);
    end
    @(negedge clk) rst_n = 1'b1;
    send(2'b00, 8'd1, 8'd1);
    wait_rsp(lat);
    e = sb.pop_front();
    checks++;
    if ({bus.rsp_lo, bus.rsp_hi, bus.rsp_flags} !== {e.lo, e.hi, e.flags} || lat != int'(e.lat)) begin
      errors++;
      $display("FAIL rst_after: got lo=%h hi=%h flg=%b lat=%0d, want lo=%h hi=%h flg=%b lat=%0d",
               bus.rsp_lo, bus.rsp_hi, bus.rsp_flags, lat, e.lo, e.hi, e.flags, e.lat);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    for (int i = 0; i < 12; i++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 40)));
      wait_rsp(lat);
      e = sb.pop_front();
      checks++;
      if ({bus.rsp_lo, bus.rsp_hi, bus.rsp_flags} !== {e.lo, e.hi, e.flags} || lat != int'(e.lat)) begin
        errors++;
        $display("FAIL b2b%0d: got lo=%h hi=%h flg=%b lat=%0d, want lo=%h hi=%h flg=%b lat=%0d",
                 i, bus.rsp_lo, bus.rsp_hi, bus.rsp_flags, lat, e.lo, e.hi, e.flags, e.lat);
      end
      ack();
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_a     = 8'd0;
    bus.req_b     = 8'd0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_addsub();
    test_muldiv();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
